// File: rtl/vc_tie_fifo.sv
// vc_tie_fifo: multi-virtual-channel input buffer for a NoC router port.
// NUM_VC independent circular FIFOs share one write port and one read port.
// The block reports per-VC full, almost-full and empty flags, returns one credit
// per dequeue, and raises one-cycle overflow and underflow error pulses.
// Optional feature macro: VC_TIE_FIFO_BYPASS_EN. When it is defined, a flit written
// to an empty VC can be read or peeked in the same cycle it is written.
module vc_tie_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int Q_DEPTH_BITS = 3,
  parameter int NUM_VC       = 4,
  parameter int AF_MARGIN    = 2,
  localparam int VC_BITS     = $clog2(NUM_VC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ON,
  input  logic                  wr_en,
  input  logic [VC_BITS-1:0]    wr_vc,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  rd_en,
  input  logic [VC_BITS-1:0]    rd_vc,
  input  logic                  peek,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic [NUM_VC-1:0]     full,
  output logic [NUM_VC-1:0]     almost_full,
  output logic [NUM_VC-1:0]     empty,
  output logic                  credit_valid,
  output logic [VC_BITS-1:0]    credit_vc,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int DEPTH = 1 << Q_DEPTH_BITS;
  localparam int CNT_W = Q_DEPTH_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(DEPTH - AF_MARGIN);

  logic [DATA_WIDTH-1:0]   mem     [NUM_VC][DEPTH];
  logic [Q_DEPTH_BITS-1:0] front_q [NUM_VC];
  logic [Q_DEPTH_BITS-1:0] rear_q  [NUM_VC];
  logic [CNT_W-1:0]        count_q [NUM_VC];

  logic              rd_cnt_zero;
  logic              wr_vc_full;
  logic              bypass_hit;
  logic              bypass_consume;
  logic              wr_acc;
  logic              wr_store;
  logic              rd_acc;
  logic              credit_next;
  logic              overflow_next;
  logic              underflow_next;
  logic [NUM_VC-1:0] wr_sel;
  logic [NUM_VC-1:0] rd_sel;

  // Decode this cycle's write/read acceptance using the counts before the clock edge.
  always_comb begin
    rd_cnt_zero = (count_q[rd_vc] == '0);
    wr_vc_full  = (count_q[wr_vc] == CNT_FULL);
`ifdef VC_TIE_FIFO_BYPASS_EN
    bypass_hit  = ON & wr_en & (rd_en | peek) & (wr_vc == rd_vc) & rd_cnt_zero;
`else
    // Without bypass, a peek only looks at stored data and never changes state.
    bypass_hit  = ON & wr_en & peek & 1'b0;
`endif
    bypass_consume = bypass_hit & rd_en;
    wr_acc         = ON & wr_en & ~wr_vc_full;
    wr_store       = wr_acc & ~bypass_consume;
    rd_acc         = ON & rd_en & ~rd_cnt_zero;
    credit_next    = rd_acc | bypass_consume;
    overflow_next  = ON & wr_en & wr_vc_full;
    underflow_next = ON & rd_en & rd_cnt_zero & ~bypass_consume;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_sel[v] = wr_store & (wr_vc == VC_BITS'(v));
      rd_sel[v] = rd_acc & (rd_vc == VC_BITS'(v));
    end
  end

  // Drive the per-VC status flags and the head flit, with the reset-time values forced.
  always_comb begin
    full        = '0;
    almost_full = '0;
    empty       = '1;
    read_data   = '0;
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        full[v]        = (count_q[v] == CNT_FULL);
        almost_full[v] = (count_q[v] >= CNT_AF);
`ifdef VC_TIE_FIFO_BYPASS_EN
        empty[v]       = (count_q[v] == '0) & ~(wr_en & (wr_vc == VC_BITS'(v)));
`else
        empty[v]       = (count_q[v] == '0);
`endif
      end
      if (bypass_hit) begin
        read_data = write_data;
      end else begin
        read_data = mem[rd_vc][front_q[rd_vc]];
      end
    end
  end

  // Advance the pointers and counts, and register the credit and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        front_q[v] <= '0;
        rear_q[v]  <= '0;
        count_q[v] <= '0;
      end
      credit_valid  <= 1'b0;
      credit_vc     <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (wr_sel[v]) begin
          rear_q[v] <= rear_q[v] + 1'b1;
        end
        if (rd_sel[v]) begin
          front_q[v] <= front_q[v] + 1'b1;
        end
        if (wr_sel[v] && !rd_sel[v]) begin
          count_q[v] <= count_q[v] + 1'b1;
        end else if (!wr_sel[v] && rd_sel[v]) begin
          count_q[v] <= count_q[v] - 1'b1;
        end
      end
      credit_valid  <= credit_next;
      if (credit_next) begin
        credit_vc <= rd_vc;
      end
      overflow_err  <= overflow_next;
      underflow_err <= underflow_next;
    end
  end

  // Store accepted flits at the tail of their VC; storage itself is never cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr_store) begin
      mem[wr_vc][rear_q[wr_vc]] <= write_data;
    end
  end

endmodule
